// File: rtl/exers_age.sv
//==============================================================================
// Module  : exers_age
// Brief   : Age-ordered reservation station for the scalu/mcalu execute pool.
//           Optional macro EXERS_PERF_EN adds occupancy / stall-cycle counters.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module exers_age #(
  parameter int RS_ENTRIES = 16,
  parameter int NUM_WB     = 2,
  parameter int ROBID_W    = 7,
  parameter int DATA_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rename_exers_write,
  input  logic [4:0]                  rename_op,
  input  logic [ROBID_W-1:0]          rename_robid,
  input  logic [5:0]                  rename_rd,
  input  logic                        rename_op1ready,
  input  logic                        rename_op2ready,
  input  logic [DATA_W-1:0]           rename_op1,
  input  logic [DATA_W-1:0]           rename_op2,
  output logic                        exers_stall,
  output logic [ROBID_W-1:0]          exers_robid,
  output logic [5:0]                  exers_rd,
  output logic [4:0]                  exers_op,
  output logic [DATA_W-1:0]           exers_op1,
  output logic [DATA_W-1:0]           exers_op2,
  output logic                        exers_scalu0_issue,
  output logic                        exers_scalu1_issue,
  output logic                        exers_mcalu0_issue,
  output logic                        exers_mcalu1_issue,
  input  logic                        scalu0_stall,
  input  logic                        scalu1_stall,
  input  logic                        mcalu0_stall,
  input  logic                        mcalu1_stall,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [NUM_WB-1:0]           wb_error,
  input  logic [NUM_WB*ROBID_W-1:0]   wb_robid,
  input  logic [NUM_WB*6-1:0]         wb_rd,
  input  logic [NUM_WB*DATA_W-1:0]    wb_result,
  input  logic                        rob_flush
`ifdef EXERS_PERF_EN
  ,
  output logic [$clog2(RS_ENTRIES):0] perf_occupancy,
  output logic [31:0]                 perf_stall_cycles
`endif
);

  localparam int IDX_W = $clog2(RS_ENTRIES);

  logic [RS_ENTRIES-1:0]                 valid_q, valid_d;
  logic [RS_ENTRIES-1:0]                 op1rdy_q, op1rdy_d, op2rdy_q, op2rdy_d;
  logic [RS_ENTRIES-1:0][4:0]            op_q, op_d;
  logic [RS_ENTRIES-1:0][5:0]            rd_q, rd_d;
  logic [RS_ENTRIES-1:0][ROBID_W-1:0]    robid_q, robid_d;
  logic [RS_ENTRIES-1:0][DATA_W-1:0]     op1_q, op1_d, op2_q, op2_d;
  logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] age_q, age_d;

  logic [NUM_WB-1:0]     wb_live;
  logic [RS_ENTRIES-1:0] ready;
  logic                  sel_found, sel_mc, sc_busy, issue_fire, free_found, accept;
  logic [IDX_W-1:0]      sel_idx, free_idx;
  logic [DATA_W:0]       ins1_wake, ins2_wake;

  always_comb begin
    wb_live = '0;
    for (int k = 0; k < NUM_WB; k++)
      wb_live[k] = wb_valid[k] & ~wb_error[k] & ~wb_rd[k*6+5];
  end

  // Returns {hit, result}; scanned high-to-low so the lowest matching bus wins.
  function automatic logic [DATA_W:0] wake(input logic [ROBID_W-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    for (int k = NUM_WB-1; k >= 0; k--)
      if (wb_live[k] && (wb_robid[k*ROBID_W +: ROBID_W] == tag))
        r = {1'b1, wb_result[k*DATA_W +: DATA_W]};
    return r;
  endfunction

  assign ready = valid_q & op1rdy_q & op2rdy_q;

  // Oldest ready entry: ready with no ready entry marked older in its column.
  always_comb begin
    logic older;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      older = 1'b0;
      for (int j = 0; j < RS_ENTRIES; j++)
        older = older | (ready[j] & age_q[j][i]);
      if (ready[i] && !older && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign sel_mc  = op_q[sel_idx][4];
  assign sc_busy = sel_mc | (scalu0_stall & scalu1_stall);

  assign exers_scalu0_issue = sel_found & ~sel_mc & ~scalu0_stall;
  assign exers_scalu1_issue = sel_found & ~sel_mc & scalu0_stall & ~scalu1_stall;
  assign exers_mcalu0_issue = sel_found & sc_busy & ~mcalu0_stall;
  assign exers_mcalu1_issue = sel_found & sc_busy & mcalu0_stall & ~mcalu1_stall;
  assign issue_fire = exers_scalu0_issue | exers_scalu1_issue |
                      exers_mcalu0_issue | exers_mcalu1_issue;

  assign exers_robid = robid_q[sel_idx];
  assign exers_rd    = rd_q[sel_idx];
  assign exers_op    = op_q[sel_idx];
  assign exers_op1   = op1_q[sel_idx];
  assign exers_op2   = op2_q[sel_idx];

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < RS_ENTRIES; i++)
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
  end

  assign exers_stall = &valid_q;
  assign accept      = rename_exers_write & ~exers_stall;
  assign ins1_wake   = wake(rename_op1[ROBID_W-1:0]);
  assign ins2_wake   = wake(rename_op2[ROBID_W-1:0]);

  always_comb begin
    logic [DATA_W:0] w;
    valid_d  = valid_q;
    op1rdy_d = op1rdy_q;
    op2rdy_d = op2rdy_q;
    op_d     = op_q;
    rd_d     = rd_q;
    robid_d  = robid_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    age_d    = age_q;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      w = wake(op1_q[i][ROBID_W-1:0]);
      if (valid_q[i] && !op1rdy_q[i] && w[DATA_W]) begin
        op1rdy_d[i] = 1'b1;
        op1_d[i]    = w[DATA_W-1:0];
      end
      w = wake(op2_q[i][ROBID_W-1:0]);
      if (valid_q[i] && !op2rdy_q[i] && w[DATA_W]) begin
        op2rdy_d[i] = 1'b1;
        op2_d[i]    = w[DATA_W-1:0];
      end
    end
    if (issue_fire)
      valid_d[sel_idx] = 1'b0;
    // free_idx comes from registered valid, so a slot freed this cycle is not reused.
    if (accept) begin
      valid_d[free_idx]  = 1'b1;
      op_d[free_idx]     = rename_op;
      rd_d[free_idx]     = rename_rd;
      robid_d[free_idx]  = rename_robid;
      op1rdy_d[free_idx] = rename_op1ready | ins1_wake[DATA_W];
      op2rdy_d[free_idx] = rename_op2ready | ins2_wake[DATA_W];
      op1_d[free_idx]    = (!rename_op1ready && ins1_wake[DATA_W]) ? ins1_wake[DATA_W-1:0] : rename_op1;
      op2_d[free_idx]    = (!rename_op2ready && ins2_wake[DATA_W]) ? ins2_wake[DATA_W-1:0] : rename_op2;
      age_d[free_idx]    = '0;
      for (int j = 0; j < RS_ENTRIES; j++)
        age_d[j][free_idx] = valid_q[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rob_flush) begin
      valid_q <= '0;
      age_q   <= '0;
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

  // Payload needs no reset; it is only observed behind valid.
  always_ff @(posedge clk) begin
    op1rdy_q <= op1rdy_d;
    op2rdy_q <= op2rdy_d;
    op_q     <= op_d;
    rd_q     <= rd_d;
    robid_q  <= robid_d;
    op1_q    <= op1_d;
    op2_q    <= op2_d;
  end

`ifdef EXERS_PERF_EN
  logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;

  always_comb begin
    perf_occupancy = '0;
    for (int i = 0; i < RS_ENTRIES; i++)
      perf_occupancy = perf_occupancy + (IDX_W+1)'(valid_q[i]);
  end

  always_comb begin
    perf_stall_cycles_d = perf_stall_cycles_q;
    if (exers_stall && rename_exers_write && (perf_stall_cycles_q != 32'hFFFF_FFFF))
      perf_stall_cycles_d = perf_stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_stall_cycles_q <= '0;
    else     perf_stall_cycles_q <= perf_stall_cycles_d;
  end

  assign perf_stall_cycles = perf_stall_cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exers_age.sv
//==============================================================================
// Module  : tb_exers_age
// Brief   : Directed vector bench for exers_age (default build).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_exers_age;

  logic        clk = 1'b0;
  logic        rst;
  logic        rename_exers_write;
  logic [4:0]  rename_op;
  logic [6:0]  rename_robid;
  logic [5:0]  rename_rd;
  logic        rename_op1ready, rename_op2ready;
  logic [31:0] rename_op1, rename_op2;
  logic        exers_stall;
  logic [6:0]  exers_robid;
  logic [5:0]  exers_rd;
  logic [4:0]  exers_op;
  logic [31:0] exers_op1, exers_op2;
  logic        s0_iss, s1_iss, m0_iss, m1_iss;
  logic        scalu0_stall, scalu1_stall, mcalu0_stall, mcalu1_stall;
  logic [1:0]  wb_valid, wb_error;
  logic [13:0] wb_robid;
  logic [11:0] wb_rd;
  logic [63:0] wb_result;
  logic        rob_flush;

  int checks   = 0;
  int failures = 0;

  exers_age dut (
    .clk(clk), .rst(rst),
    .rename_exers_write(rename_exers_write), .rename_op(rename_op),
    .rename_robid(rename_robid), .rename_rd(rename_rd),
    .rename_op1ready(rename_op1ready), .rename_op2ready(rename_op2ready),
    .rename_op1(rename_op1), .rename_op2(rename_op2),
    .exers_stall(exers_stall), .exers_robid(exers_robid), .exers_rd(exers_rd),
    .exers_op(exers_op), .exers_op1(exers_op1), .exers_op2(exers_op2),
    .exers_scalu0_issue(s0_iss), .exers_scalu1_issue(s1_iss),
    .exers_mcalu0_issue(m0_iss), .exers_mcalu1_issue(m1_iss),
    .scalu0_stall(scalu0_stall), .scalu1_stall(scalu1_stall),
    .mcalu0_stall(mcalu0_stall), .mcalu1_stall(mcalu1_stall),
    .wb_valid(wb_valid), .wb_error(wb_error), .wb_robid(wb_robid),
    .wb_rd(wb_rd), .wb_result(wb_result), .rob_flush(rob_flush)
  );

  always #5 clk = ~clk;

  // Unit bit order everywhere: {mcalu1, mcalu0, scalu1, scalu0}.
  typedef struct packed {
    logic        wr;
    logic [4:0]  op;
    logic [6:0]  robid;
    logic        o1r;
    logic [31:0] o1;
    logic        o2r;
    logic [31:0] o2;
    logic [3:0]  ustall;
    logic [1:0]  wbv, wbe;
    logic [6:0]  id0, id1;
    logic [5:0]  rd0, rd1;
    logic [31:0] res0, res1;
    logic        flush;
    logic [3:0]  exp_iss;
    logic [6:0]  exp_robid;
    logic [31:0] exp_op1, exp_op2;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;

  function automatic logic [5:0] rd_of(input logic [6:0] id);
    return {1'b0, id[4:0]};
  endfunction

  task automatic ins(input logic [6:0] id, input logic [4:0] op,
                     input logic r1, input logic [31:0] a,
                     input logic r2, input logic [31:0] b);
    cur.wr = 1'b1; cur.robid = id; cur.op = op;
    cur.o1r = r1; cur.o1 = a; cur.o2r = r2; cur.o2 = b;
  endtask

  task automatic wbus(input int k, input logic [6:0] id, input logic [5:0] rd,
                      input logic err, input logic [31:0] res);
    cur.wbv[k] = 1'b1;
    cur.wbe[k] = err;
    if (k == 0) begin cur.id0 = id; cur.rd0 = rd; cur.res0 = res; end
    else        begin cur.id1 = id; cur.rd1 = rd; cur.res1 = res; end
  endtask

  task automatic ex(input logic [3:0] iss, input logic [6:0] id,
                    input logic [31:0] a, input logic [31:0] b);
    cur.exp_iss = iss; cur.exp_robid = id; cur.exp_op1 = a; cur.exp_op2 = b;
  endtask

  task automatic push();
    vecs.push_back(cur);
    cur = '0;
  endtask

  task automatic drive(input vec_t v);
    rename_exers_write = v.wr;
    rename_op          = v.op;
    rename_robid       = v.robid;
    rename_rd          = rd_of(v.robid);
    rename_op1ready    = v.o1r;
    rename_op1         = v.o1;
    rename_op2ready    = v.o2r;
    rename_op2         = v.o2;
    {mcalu1_stall, mcalu0_stall, scalu1_stall, scalu0_stall} = v.ustall;
    wb_valid  = v.wbv;
    wb_error  = v.wbe;
    wb_robid  = {v.id1, v.id0};
    wb_rd     = {v.rd1, v.rd0};
    wb_result = {v.res1, v.res0};
    rob_flush = v.flush;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input int idx, input logic stall_exp, input logic [3:0] iss,
                             input logic [6:0] id, input logic [31:0] a, input logic [31:0] b);
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, ".stall"}, 32'(exers_stall), 32'(stall_exp));
    chk({tag, ".issue"}, 32'({m1_iss, m0_iss, s1_iss, s0_iss}), 32'(iss));
    if (iss != 4'b0000) begin
      chk({tag, ".robid"}, 32'(exers_robid), 32'(id));
      chk({tag, ".rd"},    32'(exers_rd),    32'(rd_of(id)));
      chk({tag, ".op1"},   exers_op1, a);
      chk({tag, ".op2"},   exers_op2, b);
    end
  endtask

  initial begin
    cur = '0;
    // Two ready ops back to back: A then B on scalu0.
    ins(7'd5, 5'h01, 1, 32'h11, 1, 32'h22);        push();                        // 0
    ins(7'd6, 5'h02, 1, 32'h33, 1, 32'h44); ex(4'b0001, 7'd5, 32'h11, 32'h22); push(); // 1
    ex(4'b0001, 7'd6, 32'h33, 32'h44);             push();                        // 2
    push();                                                                       // 3
    // Wakeup from bus 1 lets the older X issue after the younger Y.
    ins(7'd10, 5'h03, 0, 32'd9, 1, 32'h55);        push();                        // 4
    ins(7'd11, 5'h04, 1, 32'h66, 1, 32'h77);       push();                        // 5
    wbus(1, 7'd9, 6'h01, 0, 32'hDEAD); ex(4'b0001, 7'd11, 32'h66, 32'h77); push(); // 6
    ex(4'b0001, 7'd10, 32'hDEAD, 32'h55);          push();                        // 7
    // Same-cycle capture on insert.
    ins(7'd12, 5'h05, 1, 32'h88, 0, 32'd3); wbus(0, 7'd3, 6'h01, 0, 32'h1234); push(); // 8
    ex(4'b0001, 7'd12, 32'h88, 32'h1234);          push();                        // 9
    // mc op blocked by both mcalus, then goes to mcalu1.
    ins(7'd13, 5'h10, 1, 32'h1, 1, 32'h2);         push();                        // 10
    cur.ustall = 4'b1100;                          push();                        // 11
    cur.ustall = 4'b0100; ex(4'b1000, 7'd13, 32'h1, 32'h2); push();               // 12
    // sc op falls through to scalu1, then mcalu0.
    ins(7'd14, 5'h06, 1, 32'h3, 1, 32'h4);         push();                        // 13
    cur.ustall = 4'b0001; ex(4'b0010, 7'd14, 32'h3, 32'h4); push();               // 14
    ins(7'd15, 5'h07, 1, 32'h5, 1, 32'h6);         push();                        // 15
    cur.ustall = 4'b0011; ex(4'b0100, 7'd15, 32'h5, 32'h6); push();               // 16
    // Blocked oldest mc op holds back a younger ready sc op.
    ins(7'd20, 5'h11, 1, 32'h7, 1, 32'h8);         push();                        // 17
    ins(7'd21, 5'h08, 1, 32'h9, 1, 32'hA); cur.ustall = 4'b1100; push();          // 18
    cur.ustall = 4'b1100;                          push();                        // 19
    ex(4'b0100, 7'd20, 32'h7, 32'h8);              push();                        // 20
    ex(4'b0001, 7'd21, 32'h9, 32'hA);              push();                        // 21
    // Errored bus and no-dest bus must not wake.
    ins(7'd30, 5'h09, 0, 32'd4, 1, 32'h99);        push();                        // 22
    wbus(0, 7'd4, 6'h02, 1, 32'hBAD0);             push();                        // 23
    wbus(1, 7'd4, 6'h20, 0, 32'hBAD1);             push();                        // 24
    push();                                                                       // 25
    wbus(0, 7'd4, 6'h02, 0, 32'hBEEF);             push();                        // 26
    ex(4'b0001, 7'd30, 32'hBEEF, 32'h99);          push();                        // 27
    // Both buses match: the lower bus supplies the value.
    ins(7'd40, 5'h0A, 0, 32'd7, 1, 32'h5);         push();                        // 28
    wbus(0, 7'd7, 6'h03, 0, 32'hAAAA); wbus(1, 7'd7, 6'h04, 0, 32'hBBBB); push(); // 29
    ex(4'b0001, 7'd40, 32'hAAAA, 32'h5);           push();                        // 30

    // Reset with a write pending: the write must be dropped.
    cur = '0;
    ins(7'd1, 5'h01, 1, 32'h1, 1, 32'h1);
    drive(cur);
    cur = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(cur);
    #1;
    chk_outputs(-1, 1'b0, 4'b0000, 7'd0, 32'd0, 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk_outputs(i, 1'b0, vecs[i].exp_iss, vecs[i].exp_robid, vecs[i].exp_op1, vecs[i].exp_op2);
    end

    // Fill every entry with an op waiting on tag 100.
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      cur = '0;
      ins(7'(64 + n), 5'h01, 0, 32'd100, 1, 32'h0);
      drive(cur);
      #1;
      chk($sformatf("fill%0d.stall", n), 32'(exers_stall), 32'd0);
    end
    @(negedge clk);
    cur = '0;
    ins(7'd99, 5'h01, 1, 32'h1, 1, 32'h2);
    drive(cur);
    #1;
    chk("full.stall", 32'(exers_stall), 32'd1);
    @(negedge clk);
    cur = '0;
    drive(cur);
    #1;
    chk("full.no_issue", 32'({m1_iss, m0_iss, s1_iss, s0_iss}), 32'd0);
    chk("full.stall_hold", 32'(exers_stall), 32'd1);
    @(negedge clk);
    cur.flush = 1'b1;
    drive(cur);
    @(negedge clk);
    cur = '0;
    wbus(0, 7'd100, 6'h01, 0, 32'hF00D);
    drive(cur);
    #1;
    chk("flush.stall", 32'(exers_stall), 32'd0);
    chk("flush.issue", 32'({m1_iss, m0_iss, s1_iss, s0_iss}), 32'd0);
    @(negedge clk);
    cur = '0;
    drive(cur);
    #1;
    chk("flush.no_stale", 32'({m1_iss, m0_iss, s1_iss, s0_iss}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/exers_age.md
Name: exers_age

Overview:
Parametrised successor to the execute-unit reservation station. Holds renamed ALU ops until both operands are ready, then issues one op per cycle to the scalu/mcalu pool. Selection is oldest-first, not lowest-index. Wakeup comes from NUM_WB writeback buses, with same-cycle capture on insert. Sits between rename and the scalu0/1 and mcalu0/1 units.

Parameters:
RS_ENTRIES, 16, number of entries (power of 2, >=4)
NUM_WB, 2, number of writeback/wakeup buses
ROBID_W, 7, ROB id width; tag lives in operand bits [ROBID_W-1:0]
DATA_W, 32, operand/result width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rename_exers_write  in  1  insert request
rename_op  in  5  opcode; bit4=1 means multicycle-only (mcalu)
rename_robid  in  ROBID_W  ROB id of op
rename_rd  in  6  dest phys reg; bit5=1 means no dest
rename_op1ready / rename_op2ready  in  1  operand holds value (1) or tag (0)
rename_op1 / rename_op2  in  DATA_W  value or tag
exers_stall  out  1  no free entry; insert not accepted
exers_robid  out  ROBID_W  issued op ROB id
exers_rd  out  6  issued op dest
exers_op  out  5  issued opcode
exers_op1 / exers_op2  out  DATA_W  issued operands
exers_scalu0_issue, exers_scalu1_issue, exers_mcalu0_issue, exers_mcalu1_issue  out  1  one-hot issue strobe
scalu0_stall, scalu1_stall, mcalu0_stall, mcalu1_stall  in  1  unit busy
wb_valid  in  NUM_WB  per-bus valid
wb_error  in  NUM_WB  per-bus error (no wakeup)
wb_robid  in  NUM_WB*ROBID_W  packed, bus k at [k*ROBID_W +: ROBID_W]
wb_rd  in  NUM_WB*6  packed dest; bit5=1 means no wakeup
wb_result  in  NUM_WB*DATA_W  packed results
rob_flush  in  1  discard all entries

Behaviour:
- State: per-entry valid, op, rd, robid, opNready, opN; age matrix age[i][j]=1 iff entry i older than j.
- Reset/flush (rst|rob_flush at edge): all valid=0, age matrix cleared. Any insert/issue in that cycle is dropped. After reset: exers_stall=0, all issue strobes=0.
- Insert accepted when rename_exers_write & ~exers_stall. Entry = lowest-index invalid. Its age row is set to 0 and its age column to 1 for all other valid entries (new entry youngest).
- Wakeup bus k is live when wb_valid[k] & ~wb_error[k] & ~wb_rd[k][5]. A not-ready valid operand whose tag equals wb_robid[k] becomes ready with wb_result[k]. If several buses match, the lowest k wins.
- Insert wakeup: a not-ready incoming operand matching a live bus in the same cycle is stored ready with that result. No lost wakeups.
- Ready = valid & op1ready & op2ready. Issue candidate = the ready entry with no older ready entry. Issue outputs are combinational from registered state, so the earliest issue is the cycle after insert or wakeup.
- Routing, first non-stalled unit wins:
  - sc op (op[4]=0): scalu0, scalu1, mcalu0, mcalu1.
  - mc op: mcalu0, mcalu1 only.
  - If no eligible unit is free, no strobe and the entry stays. The oldest op blocks younger ones; no bypass past a blocked mc op.
- Issued entry valid=0 at edge. Issue and insert in the same cycle are legal. The freed slot is not reused until the next cycle.
- exers_stall = all entries valid (conservative; ignores same-cycle issue).
- Data outputs are don't-care when no strobe is asserted.

Optional Feature:
EXERS_PERF_EN:
- Defined: adds outputs perf_occupancy ($clog2(RS_ENTRIES)+1 bits, count of valid entries, combinational) and perf_stall_cycles (32 bits, increments each cycle exers_stall & rename_exers_write, saturates at 2^32-1, cleared by rst only, not by flush).
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Insert A (robid 5, both ready), then B (robid 6, both ready), all units free -> A issues on scalu0 the cycle after insert, B next cycle.
- Insert X (op1 tag 9, not ready), then Y (ready). wb bus1 robid 9 result 0xDEAD -> Y issues first. X issues the cycle after wakeup with op1=0xDEAD.
- Insert with op2 tag 3 in the same cycle wb bus0 robid 3 result 0x1234 -> entry stored ready; issues next cycle with op2=0x1234.
- mc op ready, mcalu0=mcalu1=1 stalled, scalu free -> no strobe. Release mcalu1 -> exers_mcalu1_issue=1.
- Fill all 16 entries not ready -> exers_stall=1, further write ignored. rob_flush -> next cycle stall=0, no issue strobes.
- Entries with tag 4, wb robid 4 with wb_error=1 or wb_rd=6'h20 -> no wakeup, no issue.
